arith_shift_sequencer: RTL and testbench

//  Multi-cycle arithmetic-left-shift engine downstream of the 128-bit shift register stage.

---
 rtl/arith_shift_sequencer_pkg.sv | 17 +
 rtl/arith_shift_sequencer_if.sv | 27 ++
 rtl/arith_shift_sequencer_asl_step.sv | 13 +
 rtl/arith_shift_sequencer.sv | 106 ++++++++++
 tb/tb_arith_shift_sequencer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/arith_shift_sequencer_pkg.sv
// Shared types and constants for the arithmetic-left-shift sequencer and its step cell.
package arith_shift_sequencer_pkg;

  localparam int unsigned WIDTH_DEFAULT = 128;

  // Shift-amount port width: must represent every count from 0 to w inclusive.
  function automatic int unsigned amt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/arith_shift_sequencer_if.sv
// Operand and result valid/ready handshakes plus busy status of the shift sequencer.
interface arith_shift_sequencer_if
  import arith_shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned AMT_W = amt_width(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amount;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             busy;

  modport master (
    output in_valid, in_data, in_amount, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_data, in_amount, out_ready,
    output in_ready, out_valid, out_data, out_ovf, busy
  );
endinterface

// File: rtl/arith_shift_sequencer_asl_step.sv
// Combinational single-bit arithmetic left shift; flags a sign change caused by the step.
module asl_step #(
  parameter int unsigned WIDTH = 128
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] shift_c_o,
  output logic             ovf_c_o
);

  assign shift_c_o = {data_i[WIDTH-2:0], 1'b0};
  assign ovf_c_o   = data_i[WIDTH-1] ^ data_i[WIDTH-2];

endmodule

// File: rtl/arith_shift_sequencer.sv
// Multi-cycle arithmetic left shifter: one bit per clock, sticky signed-overflow flag,
// valid/ready on both sides, one operation in flight.
module arith_shift_sequencer
  import arith_shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned AMT_W = amt_width(WIDTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  arith_shift_sequencer_if.slave   bus
);

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] out_data_q;
  logic             ovf_q;
  logic             out_ovf_q;
  logic [AMT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] shift_d;
  logic             step_ovf_d;
  logic [AMT_W-1:0] amt_clamped_d;

  asl_step #(.WIDTH(WIDTH)) u_step (
    .data_i    (data_q),
    .shift_c_o (shift_d),
    .ovf_c_o   (step_ovf_d)
  );

  // Counts beyond WIDTH produce the same result as WIDTH, so cap the counter there.
  always_comb begin
    amt_clamped_d = bus.in_amount;
    if (bus.in_amount > AMT_W'(WIDTH)) amt_clamped_d = AMT_W'(WIDTH);
  end

  // Result registers are loaded only on entry to DONE so they stay put between results.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
      out_ovf_q   <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            data_q     <= bus.in_data;
            ovf_q      <= 1'b0;
            cnt_q      <= amt_clamped_d;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (amt_clamped_d == '0) begin
              state_q     <= ST_DONE;
              out_data_q  <= bus.in_data;
              out_ovf_q   <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          data_q <= shift_d;
          ovf_q  <= ovf_q | step_ovf_d;
          cnt_q  <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_q     <= ST_DONE;
            out_data_q  <= shift_d;
            out_ovf_q   <= ovf_q | step_ovf_d;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_arith_shift_sequencer.sv
// Directed bench for arith_shift_sequencer: behavioural result model, per-cycle result monitor,
// latency, reset-abort and backpressure checks.
module tb_arith_shift_sequencer;
  import arith_shift_sequencer_pkg::*;

  localparam int unsigned W  = 128;
  localparam int unsigned AW = amt_width(W);
  localparam int          TIMEOUT = 400;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arith_shift_sequencer_if #(.WIDTH(W), .AMT_W(AW)) bus ();

  arith_shift_sequencer #(.WIDTH(W), .AMT_W(AW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         o;
  } res_t;

  typedef struct {
    logic [W-1:0] d;
    int           amt;
    logic [W-1:0] xd;
    logic         xo;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  function automatic int clamp(input int amt);
    return (amt > int'(W)) ? int'(W) : amt;
  endfunction

  // Result = operand shifted left n places; overflow iff the top n+1 bits of the operand
  // (with a zero appended below bit 0) are not all equal, i.e. the sign changed on some step.
  function automatic res_t model(input logic [W-1:0] d, input int amt);
    res_t         r;
    int           n;
    logic [W:0]   ext;
    n   = clamp(amt);
    r.d = d << n;
    r.o = 1'b0;
    ext = {d, 1'b0};
    for (int i = 1; i <= n; i++)
      if (ext[W-i] != ext[W]) r.o = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Result monitor: every cycle out_valid is high the payload must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL mon_unexpected: got out_valid=1 required no pending result");
      end else begin
        check("mon_data", bus.out_data, exp_q[0].d);
        check_int("mon_ovf", int'(bus.out_ovf), int'(exp_q[0].o));
        if (bus.out_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle(input string tag);
    int g = 0;
    while (bus.in_ready !== 1'b1 && g < TIMEOUT) begin
      step();
      g++;
    end
    if (g >= TIMEOUT) check_int({tag, "_idle_timeout"}, g, 0);
  endtask

  // Issue one operation and return once out_valid is high, reporting the latency in cycles.
  task automatic run_op(input string tag, input logic [W-1:0] d, input int amt, output int lat);
    wait_idle(tag);
    exp_q.push_back(model(d, amt));
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_amount = AW'(amt);
    step();
    bus.in_valid = 1'b0;
    check_int({tag, "_busy"}, int'(bus.busy), 1);
    check_int({tag, "_in_ready"}, int'(bus.in_ready), 0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < TIMEOUT) begin
      step();
      lat++;
    end
    check_int({tag, "_latency"}, lat, clamp(amt));
  endtask

  vec_t vecs[9];
  int   lat;
  res_t m;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{128'h1, 4, 128'h10, 1'b0};
    vecs[1] = '{128'h4000_0000_0000_0000_0000_0000_0000_0000, 1,
                128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b1};
    vecs[2] = '{128'hDEAD, 0, 128'hDEAD, 1'b0};
    vecs[3] = '{128'h5, 200, 128'h0, 1'b1};
    vecs[4] = '{128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 127,
                128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0};
    vecs[5] = '{128'h3, 126, 128'hC000_0000_0000_0000_0000_0000_0000_0000, 1'b1};
    vecs[6] = '{128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1,
                128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFC, 1'b0};
    vecs[7] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 128, 128'h0, 1'b1};
    vecs[8] = '{128'h0, 128, 128'h0, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amount = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_int("rst_in_ready", int'(bus.in_ready), 1);
    check_int("rst_out_valid", int'(bus.out_valid), 0);
    check_int("rst_busy", int'(bus.busy), 0);
    check("rst_out_data", bus.out_data, '0);

    // Directed vectors: pin the model to hand values, then the DUT to the same values.
    foreach (vecs[i]) begin
      m = model(vecs[i].d, vecs[i].amt);
      check($sformatf("model_d%0d", i), m.d, vecs[i].xd);
      check_int($sformatf("model_o%0d", i), int'(m.o), int'(vecs[i].xo));
      run_op($sformatf("v%0d", i), vecs[i].d, vecs[i].amt, lat);
      check($sformatf("v%0d_data", i), bus.out_data, vecs[i].xd);
      check_int($sformatf("v%0d_ovf", i), int'(bus.out_ovf), int'(vecs[i].xo));
      step();
      check_int($sformatf("v%0d_back_idle", i), int'(bus.in_ready), 1);
    end

    // Reset in the middle of a long shift aborts the operation.
    run_op("pre_rst", 128'h1, 4, lat);
    step();
    wait_idle("rst_mid");
    bus.in_valid  = 1'b1;
    bus.in_data   = 128'h1234;
    bus.in_amount = AW'(50);
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_int("mid_rst_in_ready", int'(bus.in_ready), 1);
    check_int("mid_rst_out_valid", int'(bus.out_valid), 0);
    check_int("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_out_data", bus.out_data, '0);
    check_int("mid_rst_out_ovf", int'(bus.out_ovf), 0);
    repeat (60) step();
    check_int("mid_rst_stays_idle", int'(bus.out_valid), 0);

    // Backpressure: result held while out_ready is low; a pending operand waits.
    bus.out_ready = 1'b0;
    run_op("bp", 128'hABCD, 3, lat);
    exp_q.push_back(model(128'h77, 0));
    bus.in_valid  = 1'b1;
    bus.in_data   = 128'h77;
    bus.in_amount = '0;
    for (int k = 0; k < 10; k++) begin
      check_int("bp_valid_held", int'(bus.out_valid), 1);
      check("bp_data_held", bus.out_data, 128'h5_5E68);
      check_int("bp_in_ready_low", int'(bus.in_ready), 0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    check_int("bp_released_valid", int'(bus.out_valid), 0);
    check_int("bp_released_in_ready", int'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    check_int("bp_second_valid", int'(bus.out_valid), 1);
    check("bp_second_data", bus.out_data, 128'h77);
    step();
    step();

    check_int("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
